brcomp_arb: RTL

Two-requester arbiter and 2-stage pipeline wrapper around one shared branch/less-than comparator. Requester 0 is the branch unit (BEQ..BGEU decisions). Requester 1 is the ALU set-less-than path (SLT/SLTU). The block:
- grants at most one request per cycle;
- registers operands, evaluates equal/less and the funct3 condition;
- returns a tagged result through a valid/ready response port with full backpressure.

---
 rtl/brcomp_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/brcomp_arb.sv
// Two-requester arbiter feeding a shared 2-stage branch/set-less-than comparator.
// Requester 0 is the branch unit, requester 1 the ALU SLT path; responses are tagged and in order.
module brcomp_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [31:0] i_req0_rs1,
  input  logic [31:0] i_req0_rs2,
  input  logic [2:0]  i_req0_funct3,
  input  logic [31:0] i_req1_rs1,
  input  logic [31:0] i_req1_rs2,
  input  logic [2:0]  i_req1_funct3,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic        o_rsp_equal,
  output logic        o_rsp_less,
  output logic        o_rsp_taken,
  output logic        o_rsp_illegal
);
  localparam int DATA_W = 32;

  logic              r_vld_p1;
  logic              r_id_p1;
  logic [DATA_W-1:0] r_rs1_p1;
  logic [DATA_W-1:0] r_rs2_p1;
  logic [2:0]        r_f3_p1;
  logic              r_lg;

  logic              r_vld_p2;
  logic              r_id_p2;
  logic              r_eq_p2;
  logic              r_less_p2;
  logic              r_taken_p2;
  logic              r_ill_p2;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic [1:0]        w_grant;
  logic              w_gid;
  logic              w_xfer;
  logic [DATA_W-1:0] w_rs1;
  logic [DATA_W-1:0] w_rs2;
  logic [2:0]        w_f3;
  logic [3:0]        w_cmp;

  // Returns {equal, less, taken, illegal}; less comes from a 33-bit subtract so
  // both signed and unsigned forms share one adder.
  function automatic logic [3:0] cmp_eval(input logic [DATA_W-1:0] rs1,
                                          input logic [DATA_W-1:0] rs2,
                                          input logic [2:0]        f3);
    logic [DATA_W:0] sub;
    logic            eq;
    logic            lt;
    logic            ovf;
    logic            tk;
    logic            ill;
    sub = {1'b0, rs1} - {1'b0, rs2};
    eq  = (rs1 == rs2);
    ovf = (rs1[DATA_W-1] ^ rs2[DATA_W-1]) & (rs1[DATA_W-1] ^ sub[DATA_W-1]);
    lt  = f3[1] ? sub[DATA_W] : (sub[DATA_W-1] ^ ovf);
    tk  = 1'b0;
    ill = 1'b0;
    case (f3)
      3'b000:          tk = eq;
      3'b001:          tk = !eq;
      3'b100, 3'b110:  tk = lt;
      3'b101, 3'b111:  tk = !lt;
      default:         ill = 1'b1;
    endcase
    return {eq, lt, tk, ill};
  endfunction

  assign w_s2_adv = !r_vld_p2 | i_rsp_ready;
  assign w_s1_adv = !r_vld_p1 | w_s2_adv;

  always_comb begin
    w_grant = 2'b00;
    case (i_req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = (RR_EN && !r_lg) ? 2'b10 : 2'b01;
      default: w_grant = 2'b00;
    endcase
  end

  assign o_req_ready = w_grant & {2{w_s1_adv & i_rst_n}};
  assign w_xfer      = |(i_req_valid & o_req_ready);
  assign w_gid       = w_grant[1];
  assign w_rs1       = w_gid ? i_req1_rs1    : i_req0_rs1;
  assign w_rs2       = w_gid ? i_req1_rs2    : i_req0_rs2;
  assign w_f3        = w_gid ? i_req1_funct3 : i_req0_funct3;

  // Stage 1: operand capture from the granted requester
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_p1 <= 1'b0;
      r_id_p1  <= 1'b0;
      r_rs1_p1 <= '0;
      r_rs2_p1 <= '0;
      r_f3_p1  <= 3'b000;
      r_lg     <= 1'b1;
    end else if (w_s1_adv) begin
      r_vld_p1 <= w_xfer;
      if (w_xfer) begin
        r_id_p1  <= w_gid;
        r_rs1_p1 <= w_rs1;
        r_rs2_p1 <= w_rs2;
        r_f3_p1  <= w_f3;
        r_lg     <= w_gid;
      end
    end
  end

  assign w_cmp = cmp_eval(r_rs1_p1, r_rs2_p1, r_f3_p1);

  // Stage 2: registered compare result, held while the consumer stalls
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_p2   <= 1'b0;
      r_id_p2    <= 1'b0;
      r_eq_p2    <= 1'b0;
      r_less_p2  <= 1'b0;
      r_taken_p2 <= 1'b0;
      r_ill_p2   <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_p2   <= r_vld_p1;
      r_id_p2    <= r_id_p1;
      r_eq_p2    <= w_cmp[3];
      r_less_p2  <= w_cmp[2];
      r_taken_p2 <= w_cmp[1];
      r_ill_p2   <= w_cmp[0];
    end
  end

  assign o_rsp_valid   = r_vld_p2;
  assign o_rsp_id      = r_id_p2;
  assign o_rsp_equal   = r_eq_p2;
  assign o_rsp_less    = r_less_p2;
  assign o_rsp_taken   = r_taken_p2;
  assign o_rsp_illegal = r_ill_p2;

endmodule
